// File: rtl/pwm_breath_gen.sv
// Breathing-LED duty source: ramps duty up, holds, ramps down, holds, stepping only on PWM period ticks.
// Optional square-law brightness shaping is enabled by defining PWM_BREATH_GAMMA_EN.
module pwm_breath_gen #(
  parameter int WIDTH        = 8,
  parameter int STEP         = 1,
  parameter int STEP_DIV     = 4,
  parameter int HOLD_PERIODS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             period_tick,
  output logic [WIDTH-1:0] duty,
  output logic             duty_upd,
  output logic [2:0]       phase
);

  localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [WIDTH-1:0]  MAX       = '1;
  localparam logic [WIDTH-1:0]  STEP_L    = WIDTH'(STEP);
  localparam logic [WIDTH:0]    STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t              state_reg;
  logic [WIDTH-1:0]    level_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [WIDTH-1:0]    duty_reg;
  logic                duty_upd_reg;
  logic [WIDTH-1:0]    shaped;

  logic           tick;
  logic           step_evt;
  logic           hold_done;
  logic [WIDTH:0] level_up;

  assign tick      = period_tick & en;
  assign step_evt  = tick && (div_cnt_reg == DIV_LAST);
  assign hold_done = tick && (hold_cnt_reg == HOLD_LAST);
  assign level_up  = {1'b0, level_reg} + STEP_X;

  // en=0 is checked before the state case so it beats a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      level_reg    <= '0;
      div_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
    end else if (!en) begin
      state_reg    <= IDLE;
      level_reg    <= '0;
      div_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= RISE;
          level_reg    <= '0;
          div_cnt_reg  <= '0;
          hold_cnt_reg <= '0;
        end
        RISE: begin
          if (tick) div_cnt_reg <= step_evt ? '0 : div_cnt_reg + 1'b1;
          if (step_evt) begin
            if (level_up >= {1'b0, MAX}) begin
              level_reg    <= MAX;
              state_reg    <= HOLD_HI;
              hold_cnt_reg <= '0;
            end else begin
              level_reg <= level_up[WIDTH-1:0];
            end
          end
        end
        HOLD_HI: begin
          if (hold_done) begin
            hold_cnt_reg <= '0;
            div_cnt_reg  <= '0;
            state_reg    <= FALL;
          end else if (tick) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        FALL: begin
          if (tick) div_cnt_reg <= step_evt ? '0 : div_cnt_reg + 1'b1;
          if (step_evt) begin
            if (level_reg <= STEP_L) begin
              level_reg    <= '0;
              state_reg    <= HOLD_LO;
              hold_cnt_reg <= '0;
            end else begin
              level_reg <= level_reg - STEP_L;
            end
          end
        end
        HOLD_LO: begin
          if (hold_done) begin
            hold_cnt_reg <= '0;
            div_cnt_reg  <= '0;
            state_reg    <= RISE;
          end else if (tick) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          level_reg    <= '0;
          div_cnt_reg  <= '0;
          hold_cnt_reg <= '0;
        end
      endcase
    end
  end

`ifdef PWM_BREATH_GAMMA_EN
  logic [2*WIDTH-1:0] level_sq;
  logic [WIDTH-1:0]   shaped_reg;

  assign level_sq = {{WIDTH{1'b0}}, level_reg} * {{WIDTH{1'b0}}, level_reg};

  // Full scale is pinned to MAX; the plain square law would top out one short.
  always_ff @(posedge clk) begin
    if (reset) shaped_reg <= '0;
    else       shaped_reg <= (level_reg == MAX) ? MAX : WIDTH'(level_sq >> WIDTH);
  end

  assign shaped = shaped_reg;
`else
  assign shaped = level_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_reg     <= '0;
      duty_upd_reg <= 1'b0;
    end else begin
      duty_reg     <= shaped;
      duty_upd_reg <= (shaped != duty_reg);
    end
  end

  assign duty     = duty_reg;
  assign duty_upd = duty_upd_reg;
  assign phase    = state_reg;

endmodule

// File: tb/tb_pwm_breath_gen.sv
// Scoreboard bench for pwm_breath_gen: a default-step instance for the full breathing cycle
// and a STEP=100 instance for saturation and underflow edges.
module tb_pwm_breath_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       en_big;
  logic       period_tick;
  logic [7:0] duty, duty_big;
  logic       duty_upd, duty_upd_big;
  logic [2:0] phase, phase_big;

  int n_checks = 0;
  int n_fail   = 0;
  int q_main[$];
  int q_big[$];
  int last_main = 0;
  int last_big  = 0;
  int prev_main = 0;
  int prev_big  = 0;
  logic rst_q = 1'b0;

`ifdef PWM_BREATH_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  always #5 clk = ~clk;

  pwm_breath_gen u_dut (
    .clk(clk), .reset(reset), .en(en), .period_tick(period_tick),
    .duty(duty), .duty_upd(duty_upd), .phase(phase)
  );

  pwm_breath_gen #(.STEP(100), .STEP_DIV(1), .HOLD_PERIODS(2)) u_big (
    .clk(clk), .reset(reset), .en(en_big), .period_tick(period_tick),
    .duty(duty_big), .duty_upd(duty_upd_big), .phase(phase_big)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gam(input int l);
`ifdef PWM_BREATH_GAMMA_EN
    return (l == 255) ? 255 : ((l * l) >> 8);
`else
    return l;
`endif
  endfunction

  // Only value changes produce a duty_upd, so repeats are not queued.
  task automatic push_exp(input int which, input int lvl);
    int v;
    v = gam(lvl);
    if (which == 0) begin
      if (v != last_main) q_main.push_back(v);
      last_main = v;
    end else begin
      if (v != last_big) q_big.push_back(v);
      last_big = v;
    end
  endtask

  task automatic do_tick();
    @(negedge clk) period_tick = 1'b1;
    @(negedge clk) period_tick = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    if (rst_q) begin
      check_val("rst_duty", int'(duty), 0);
      check_val("rst_phase", int'(phase), 0);
      check_val("rst_upd", int'(duty_upd), 0);
      check_val("rst_duty_big", int'(duty_big), 0);
    end
    check_val("upd_align", int'(duty_upd), int'(int'(duty) != prev_main));
    check_val("upd_align_big", int'(duty_upd_big), int'(int'(duty_big) != prev_big));
    if (duty_upd) begin
      check_val("sb_nonempty", int'(q_main.size() != 0), 1);
      if (q_main.size() != 0) check_val("duty", int'(duty), q_main.pop_front());
    end
    if (duty_upd_big) begin
      check_val("sb_nonempty_big", int'(q_big.size() != 0), 1);
      if (q_big.size() != 0) check_val("duty_big", int'(duty_big), q_big.pop_front());
    end
    prev_main = int'(duty);
    prev_big  = int'(duty_big);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for 3 edges while enabled and ticking
    reset = 1'b1; en = 1'b1; en_big = 1'b0; period_tick = 1'b1;
    @(negedge clk) period_tick = 1'b0;
    @(negedge clk) period_tick = 1'b1;
    @(negedge clk) begin period_tick = 1'b0; reset = 1'b0; end
    @(negedge clk);
    check_val("start_phase", int'(phase), 1);
    $display("reset released, phase=%0d duty=%0d", phase, duty);

    // Rise: first step with explicit latency observation
    push_exp(0, 1);
    repeat (3) do_tick();
    @(negedge clk) period_tick = 1'b1;
    @(negedge clk) period_tick = 1'b0;
    check_val("lat_old_duty", int'(duty), 0);
    @(negedge clk);
    check_val("lat_new_duty", int'(duty), gam(1));
    repeat (7) @(negedge clk);
    for (int k = 2; k <= 255; k++) begin
      push_exp(0, k);
      repeat (4) do_tick();
    end
    check_val("rise_top_duty", int'(duty), gam(255));
    check_val("rise_top_phase", int'(phase), 2);
    $display("rise done, phase=%0d duty=%0d", phase, duty);

    // Hold high then fall
    repeat (15) do_tick();
    check_val("hold_hi_phase", int'(phase), 2);
    do_tick();
    check_val("fall_phase", int'(phase), 3);
    for (int k = 254; k >= 0; k--) begin
      push_exp(0, k);
      repeat (4) do_tick();
    end
    check_val("fall_bot_duty", int'(duty), 0);
    check_val("hold_lo_phase", int'(phase), 4);
    repeat (15) do_tick();
    check_val("hold_lo_end_phase", int'(phase), 4);
    do_tick();
    check_val("rise_again_phase", int'(phase), 1);
    $display("fall done, phase=%0d duty=%0d", phase, duty);

    // Ramp to 37, then drop en on the same cycle as a tick
    for (int k = 1; k <= 37; k++) begin
      push_exp(0, k);
      repeat (4) do_tick();
    end
    check_val("mid_duty", int'(duty), gam(37));
    push_exp(0, 0);
    @(negedge clk) begin period_tick = 1'b1; en = 1'b0; end
    @(negedge clk) period_tick = 1'b0;
    check_val("en_off_phase", int'(phase), 0);
    repeat (LAT) @(negedge clk);
    check_val("en_off_duty", int'(duty), 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check_val("restart_phase", int'(phase), 1);
    for (int k = 1; k <= 2; k++) begin
      push_exp(0, k);
      repeat (4) do_tick();
    end
    check_val("restart_duty", int'(duty), gam(2));
    $display("en toggle done, phase=%0d duty=%0d", phase, duty);
    push_exp(0, 0);
    en = 1'b0;
    repeat (4) @(negedge clk);

    // Large step: saturation on rise, no underflow on fall
    en_big = 1'b1;
    repeat (2) @(negedge clk);
    check_val("big_start_phase", int'(phase_big), 1);
    push_exp(1, 100); do_tick();
    push_exp(1, 200); do_tick();
    push_exp(1, 255); do_tick();
    check_val("big_top_duty", int'(duty_big), gam(255));
    check_val("big_top_phase", int'(phase_big), 2);
    do_tick();
    check_val("big_hold_phase", int'(phase_big), 2);
    do_tick();
    check_val("big_fall_phase", int'(phase_big), 3);
    push_exp(1, 155); do_tick();
    push_exp(1, 55);  do_tick();
    push_exp(1, 0);   do_tick();
    check_val("big_bot_duty", int'(duty_big), 0);
    check_val("big_bot_phase", int'(phase_big), 4);
    $display("big step done, phase=%0d duty=%0d", phase_big, duty_big);

    repeat (5) @(negedge clk);
    check_val("sb_drained", q_main.size(), 0);
    check_val("sb_drained_big", q_big.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
